// File: rtl/tag_probe_sched_if.sv
// Bundles the request, probe (AR/R) and classified-output channels of tag_probe_sched.
// The slave modport is the scheduler's view; the master modport is its environment's view.
interface tag_probe_sched_if #(
  parameter int TAG_BIT_SIZE = 8,
  parameter int ID_W         = 2
);
  logic                    rd_req_valid_i;
  logic                    rd_req_ready_o;
  logic [80:0]             rd_req_data_i;
  logic                    wr_req_valid_i;
  logic                    wr_req_ready_o;
  logic [80:0]             wr_req_data_i;
  logic                    arvalid_o;
  logic                    arready_i;
  logic [63:0]             araddr_o;
  logic [ID_W-1:0]         arid_o;
  logic                    rvalid_i;
  logic                    rready_o;
  logic [ID_W-1:0]         rid_i;
  logic [TAG_BIT_SIZE-1:0] rtag_i;
  logic [63:0]             rdata_i;
  logic                    out_valid_o;
  logic                    out_ready_i;
  logic [80:0]             out_data_o;
  logic [1:0]              out_class_o;
  logic [ID_W:0]           outstanding_o;
  logic                    orphan_err_o;

  modport slave (
    input  rd_req_valid_i, rd_req_data_i, wr_req_valid_i, wr_req_data_i,
    input  arready_i, rvalid_i, rid_i, rtag_i, rdata_i, out_ready_i,
    output rd_req_ready_o, wr_req_ready_o, arvalid_o, araddr_o, arid_o,
    output rready_o, out_valid_o, out_data_o, out_class_o, outstanding_o, orphan_err_o
  );

  modport master (
    output rd_req_valid_i, rd_req_data_i, wr_req_valid_i, wr_req_data_i,
    output arready_i, rvalid_i, rid_i, rtag_i, rdata_i, out_ready_i,
    input  rd_req_ready_o, wr_req_ready_o, arvalid_o, araddr_o, arid_o,
    input  rready_o, out_valid_o, out_data_o, out_class_o, outstanding_o, orphan_err_o
  );
endinterface

// File: rtl/tag_probe_sched.sv
// Tag-probe scheduler: arbitrates read/write requests, issues one AR probe per request and
// classifies each R response as hit/miss. Define TAG_PROBE_SCHED_STATS_EN for per-class counters.
module tag_probe_sched #(
  parameter int TAG_BIT_SIZE    = 8,
  parameter int MAX_OUTSTANDING = 4,
  parameter int ID_W            = 2
) (
  input  logic                clk,
  input  logic                rst,
  tag_probe_sched_if.slave    bus
`ifdef TAG_PROBE_SCHED_STATS_EN
  ,
  output logic [31:0]         rhit_cnt_o,
  output logic [31:0]         rmiss_cnt_o,
  output logic [31:0]         whit_cnt_o,
  output logic [31:0]         wmiss_cnt_o
`endif
);

  typedef enum logic {S_IDLE, S_ISSUE} state_e;

  state_e                     state_q, state_d;
  logic [MAX_OUTSTANDING-1:0] slotValid_q, slotValid_d;
  logic [80:0]                slotReq_q [MAX_OUTSTANDING];
  logic [80:0]                slotReq_d [MAX_OUTSTANDING];
  logic                       lastWr_q, lastWr_d;
  logic [63:0]                arAddr_q, arAddr_d;
  logic [ID_W-1:0]            arId_q, arId_d;
  logic                       outValid_q, outValid_d;
  logic [80:0]                outData_q, outData_d;
  logic [1:0]                 outClass_q, outClass_d;
  logic                       orphan_q, orphan_d;

  logic                       anyFree;
  logic [ID_W-1:0]            freeIdx;
  logic                       rdReady, wrReady, reqFire;
  logic                       arValid;
  logic                       rReady, respFire, outFire;
  logic [80:0]                reqData;
  logic [ID_W:0]              occupied;
  logic                       unusedBits;

  // Lowest-index free slot, taken from the registered valid vector so a slot freed
  // by a response this cycle only becomes allocatable next cycle.
  always_comb begin
    anyFree = 1'b0;
    freeIdx = '0;
    for (int i = MAX_OUTSTANDING - 1; i >= 0; i--) begin
      if (!slotValid_q[i]) begin
        anyFree = 1'b1;
        freeIdx = ID_W'(i);
      end
    end
  end

  always_comb begin
    occupied = '0;
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      occupied = occupied + {{ID_W{1'b0}}, slotValid_q[i]};
    end
  end

  always_comb begin
    state_d = state_q;
    rdReady = 1'b0;
    wrReady = 1'b0;
    arValid = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (anyFree) begin
          if (bus.rd_req_valid_i && (!bus.wr_req_valid_i || lastWr_q)) begin
            rdReady = 1'b1;
          end else if (bus.wr_req_valid_i) begin
            wrReady = 1'b1;
          end
        end
        if (rdReady || wrReady) begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        arValid = 1'b1;
        if (bus.arready_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign reqFire  = rdReady || wrReady;
  assign reqData  = wrReady ? bus.wr_req_data_i : bus.rd_req_data_i;
  assign rReady   = !outValid_q || bus.out_ready_i;
  assign respFire = bus.rvalid_i && rReady;
  assign outFire  = outValid_q && bus.out_ready_i;

  // Response and allocation touch different slots: one frees a valid slot, the other
  // fills a slot that was free before the edge.
  always_comb begin
    slotValid_d = slotValid_q;
    slotReq_d   = slotReq_q;
    lastWr_d    = lastWr_q;
    arAddr_d    = arAddr_q;
    arId_d      = arId_q;
    outValid_d  = outValid_q;
    outData_d   = outData_q;
    outClass_d  = outClass_q;
    orphan_d    = orphan_q;
    if (outFire) begin
      outValid_d = 1'b0;
    end
    if (respFire) begin
      if (slotValid_q[bus.rid_i]) begin
        slotValid_d[bus.rid_i] = 1'b0;
        outValid_d = 1'b1;
        outData_d  = slotReq_q[bus.rid_i];
        outClass_d = {slotReq_q[bus.rid_i][80],
                      slotReq_q[bus.rid_i][63 -: TAG_BIT_SIZE] != bus.rtag_i};
      end else begin
        orphan_d = 1'b1;
      end
    end
    if (reqFire) begin
      slotValid_d[freeIdx] = 1'b1;
      slotReq_d[freeIdx]   = {wrReady, reqData[79:0]};
      arAddr_d             = reqData[63:0];
      arId_d               = freeIdx;
      lastWr_d             = wrReady;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      slotValid_q <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        slotReq_q[i] <= '0;
      end
      lastWr_q    <= 1'b1;
      arAddr_q    <= '0;
      arId_q      <= '0;
      outValid_q  <= 1'b0;
      outData_q   <= '0;
      outClass_q  <= '0;
      orphan_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      slotValid_q <= slotValid_d;
      slotReq_q   <= slotReq_d;
      lastWr_q    <= lastWr_d;
      arAddr_q    <= arAddr_d;
      arId_q      <= arId_d;
      outValid_q  <= outValid_d;
      outData_q   <= outData_d;
      outClass_q  <= outClass_d;
      orphan_q    <= orphan_d;
    end
  end

  assign bus.rd_req_ready_o = rdReady;
  assign bus.wr_req_ready_o = wrReady;
  assign bus.arvalid_o      = arValid;
  assign bus.araddr_o       = arValid ? arAddr_q : 64'd0;
  assign bus.arid_o         = arValid ? arId_q : '0;
  assign bus.rready_o       = rReady;
  assign bus.out_valid_o    = outValid_q;
  assign bus.out_data_o     = outData_q;
  assign bus.out_class_o    = outClass_q;
  assign bus.outstanding_o  = occupied;
  assign bus.orphan_err_o   = orphan_q;

  // Response payload and the request's top bit are carried but never inspected.
  assign unusedBits = ^{bus.rdata_i, bus.rd_req_data_i[80], bus.wr_req_data_i[80]};

`ifdef TAG_PROBE_SCHED_STATS_EN
  logic [31:0] statCnt_q [4];
  logic [31:0] statCnt_d [4];

  always_comb begin
    statCnt_d = statCnt_q;
    if (outFire && statCnt_q[outClass_q] != 32'hFFFF_FFFF) begin
      statCnt_d[outClass_q] = statCnt_q[outClass_q] + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        statCnt_q[i] <= '0;
      end
    end else begin
      statCnt_q <= statCnt_d;
    end
  end

  assign rhit_cnt_o  = statCnt_q[0];
  assign rmiss_cnt_o = statCnt_q[1];
  assign whit_cnt_o  = statCnt_q[2];
  assign wmiss_cnt_o = statCnt_q[3];
`endif

endmodule

// File: tb/tb_tag_probe_sched.sv
// Self-checking bench for tag_probe_sched: a slot model predicts each classified output,
// which a monitor pops and compares at every output handshake.
module tb_tag_probe_sched;
  localparam int TAG = 8;
  localparam int MO  = 4;
  localparam int IDW = 2;

  typedef struct packed {
    logic [1:0]  cls;
    logic [80:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  exp_t expQ [$];
  bit   tbValid [MO];
  logic [80:0] tbData [MO];

  always #5 clk = ~clk;

  tag_probe_sched_if #(.TAG_BIT_SIZE(TAG), .ID_W(IDW)) bus ();

`ifdef TAG_PROBE_SCHED_STATS_EN
  logic [31:0] rhitCnt, rmissCnt, whitCnt, wmissCnt;
`endif

  tag_probe_sched #(.TAG_BIT_SIZE(TAG), .MAX_OUTSTANDING(MO), .ID_W(IDW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef TAG_PROBE_SCHED_STATS_EN
    ,
    .rhit_cnt_o  (rhitCnt),
    .rmiss_cnt_o (rmissCnt),
    .whit_cnt_o  (whitCnt),
    .wmiss_cnt_o (wmissCnt)
`endif
  );

  function automatic logic [80:0] mk(bit b80, logic [15:0] meta, logic [7:0] tag, logic [55:0] low);
    return {b80, meta, tag, low};
  endfunction

  function automatic int model_alloc(bit isWr, logic [80:0] d);
    for (int i = 0; i < MO; i++) begin
      if (!tbValid[i]) begin
        tbValid[i] = 1'b1;
        tbData[i]  = {isWr, d[79:0]};
        return i;
      end
    end
    return -1;
  endfunction

  function automatic void model_resp(int rid, logic [7:0] tag);
    exp_t e;
    if (tbValid[rid]) begin
      e.data = tbData[rid];
      e.cls  = {tbData[rid][80], tbData[rid][63:56] != tag};
      expQ.push_back(e);
      tbValid[rid] = 1'b0;
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < MO; i++) tbValid[i] = 1'b0;
    expQ.delete();
  endfunction

  // Scoreboard side: every output handshake must match the oldest prediction.
  always begin : monitor
    exp_t e;
    @(negedge clk);
    #2;
    if (!rst && bus.out_valid_o && bus.out_ready_i) begin
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL sb_extra got class=%0d data=%h want no output", bus.out_class_o, bus.out_data_o);
      end else begin
        e = expQ.pop_front();
        if ({bus.out_class_o, bus.out_data_o} !== e) begin
          errors++;
          $display("[TB] FAIL sb_output got class=%0d data=%h want class=%0d data=%h",
                   bus.out_class_o, bus.out_data_o, e.cls, e.data);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus_idle();
    bus.rd_req_valid_i = 1'b0;
    bus.rd_req_data_i  = '0;
    bus.wr_req_valid_i = 1'b0;
    bus.wr_req_data_i  = '0;
    bus.arready_i      = 1'b1;
    bus.rvalid_i       = 1'b0;
    bus.rid_i          = '0;
    bus.rtag_i         = '0;
    bus.rdata_i        = '0;
    bus.out_ready_i    = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    applyStimulus_idle();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Presents one request, waits for its grant, and returns on the negedge after it.
  task automatic send_req(input bit isWr, input logic [80:0] d, output int slot);
    int n;
    n = 0;
    slot = -1;
    if (isWr) begin
      bus.wr_req_valid_i = 1'b1;
      bus.wr_req_data_i  = d;
    end else begin
      bus.rd_req_valid_i = 1'b1;
      bus.rd_req_data_i  = d;
    end
    #1;
    while (!(isWr ? bus.wr_req_ready_o : bus.rd_req_ready_o) && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 40) begin
      checks++;
      errors++;
      $display("[TB] FAIL req_timeout got no grant want grant within 40 cycles");
    end else begin
      slot = model_alloc(isWr, d);
    end
    @(negedge clk);
    bus.rd_req_valid_i = 1'b0;
    bus.wr_req_valid_i = 1'b0;
  endtask

  // Presents one response; returns on the negedge after its handshake with rvalid still high.
  task automatic send_resp(input int rid, input logic [7:0] tag);
    int n;
    n = 0;
    bus.rvalid_i = 1'b1;
    bus.rid_i    = IDW'(rid);
    bus.rtag_i   = tag;
    bus.rdata_i  = {$urandom, $urandom};
    #1;
    while (!bus.rready_o && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 40) begin
      checks++;
      errors++;
      $display("[TB] FAIL resp_timeout got rready=0 want rready within 40 cycles");
    end else begin
      model_resp(rid, tag);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    applyStimulus_idle();
    model_reset();
    #1;
    checks++;
    if ({bus.arvalid_o, bus.araddr_o, bus.arid_o} !== {1'b0, 64'd0, 2'd0}) begin
      errors++;
      $display("[TB] FAIL reset_ar got %b/%h/%0d want 0/0/0", bus.arvalid_o, bus.araddr_o, bus.arid_o);
    end
    checks++;
    if ({bus.out_valid_o, bus.out_data_o, bus.out_class_o} !== {1'b0, 81'd0, 2'd0}) begin
      errors++;
      $display("[TB] FAIL reset_out got %b/%h/%0d want 0/0/0", bus.out_valid_o, bus.out_data_o, bus.out_class_o);
    end
    checks++;
    if ({bus.outstanding_o, bus.orphan_err_o, bus.rready_o} !== {3'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("[TB] FAIL reset_status got outst=%0d orphan=%b rready=%b want 0/0/1",
               bus.outstanding_o, bus.orphan_err_o, bus.rready_o);
    end
    checks++;
    if ({bus.rd_req_ready_o, bus.wr_req_ready_o} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL reset_ready got %b%b want 00", bus.rd_req_ready_o, bus.wr_req_ready_o);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single_read();
    logic [80:0] d;
    int slot;
    do_reset();
    d = mk(1'b1, 16'hBEEF, 8'hAB, 56'h00_0000_0000_1234);
    send_req(1'b0, d, slot);
    checks++;
    if ({bus.arvalid_o, bus.arid_o, bus.araddr_o} !== {1'b1, 2'd0, 64'hAB00_0000_0000_1234}) begin
      errors++;
      $display("[TB] FAIL rd_issue got %b/%0d/%h want 1/0/ab00000000001234", bus.arvalid_o, bus.arid_o, bus.araddr_o);
    end
    checks++;
    if (bus.outstanding_o !== 3'd1) begin
      errors++;
      $display("[TB] FAIL rd_outst1 got %0d want 1", bus.outstanding_o);
    end
    @(negedge clk);
    checks++;
    if (bus.arvalid_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rd_ar_drop got %b want 0", bus.arvalid_o);
    end
    send_resp(0, 8'hAB);
    bus.rvalid_i = 1'b0;
    checks++;
    if ({bus.out_valid_o, bus.out_class_o, bus.out_data_o[80], bus.orphan_err_o} !== {1'b1, 2'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL rd_out got v=%b cls=%0d w=%b orphan=%b want 1/0/0/0",
               bus.out_valid_o, bus.out_class_o, bus.out_data_o[80], bus.orphan_err_o);
    end
    @(negedge clk);
    checks++;
    if ({bus.out_valid_o, bus.outstanding_o} !== {1'b0, 3'd0}) begin
      errors++;
      $display("[TB] FAIL rd_done got v=%b outst=%0d want 0/0", bus.out_valid_o, bus.outstanding_o);
    end
  endtask

  task automatic test_write();
    int slot;
    do_reset();
    send_req(1'b1, mk(1'b0, 16'h0F0F, 8'h12, 56'h55), slot);
    checks++;
    if ({bus.outstanding_o, bus.arid_o} !== {3'd1, 2'd0}) begin
      errors++;
      $display("[TB] FAIL wr_outst got %0d/%0d want 1/0", bus.outstanding_o, bus.arid_o);
    end
    @(negedge clk);
    send_resp(0, 8'h13);
    bus.rvalid_i = 1'b0;
    checks++;
    if ({bus.out_class_o, bus.out_data_o[80], bus.outstanding_o} !== {2'd3, 1'b1, 3'd0}) begin
      errors++;
      $display("[TB] FAIL wr_out got cls=%0d w=%b outst=%0d want 3/1/0",
               bus.out_class_o, bus.out_data_o[80], bus.outstanding_o);
    end
    @(negedge clk);
  endtask

  task automatic test_arbitration();
    logic [80:0] rdD, wrD;
    logic [1:0]  grantTab [12];
    logic [1:0]  g;
    int slot;
    grantTab = '{2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    do_reset();
    rdD = mk(1'b1, 16'h1111, 8'h55, 56'h0A);
    wrD = mk(1'b0, 16'h2222, 8'h66, 56'h0B);
    bus.rd_req_valid_i = 1'b1;
    bus.rd_req_data_i  = rdD;
    bus.wr_req_valid_i = 1'b1;
    bus.wr_req_data_i  = wrD;
    for (int c = 0; c < 12; c++) begin
      #1;
      g = {bus.rd_req_ready_o, bus.wr_req_ready_o};
      checks++;
      if (g !== grantTab[c]) begin
        errors++;
        $display("[TB] FAIL arb_grant cycle %0d got %b want %b", c, g, grantTab[c]);
      end
      if (grantTab[c] == 2'b10) slot = model_alloc(1'b0, rdD);
      if (grantTab[c] == 2'b01) slot = model_alloc(1'b1, wrD);
      @(negedge clk);
    end
    checks++;
    if (bus.outstanding_o !== 3'd4) begin
      errors++;
      $display("[TB] FAIL arb_full got %0d want 4", bus.outstanding_o);
    end
    bus.rvalid_i = 1'b1;
    bus.rid_i    = 2'd1;
    bus.rtag_i   = 8'h66;
    #1;
    checks++;
    if ({bus.rd_req_ready_o, bus.wr_req_ready_o} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL arb_freeing got %b%b want 00", bus.rd_req_ready_o, bus.wr_req_ready_o);
    end
    model_resp(1, 8'h66);
    @(negedge clk);
    bus.rvalid_i = 1'b0;
    #1;
    checks++;
    if ({bus.rd_req_ready_o, bus.wr_req_ready_o} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL arb_refill got %b%b want 10", bus.rd_req_ready_o, bus.wr_req_ready_o);
    end
    slot = model_alloc(1'b0, rdD);
    @(negedge clk);
    bus.rd_req_valid_i = 1'b0;
    bus.wr_req_valid_i = 1'b0;
    checks++;
    if ({bus.arvalid_o, bus.arid_o} !== {1'b1, 2'd1}) begin
      errors++;
      $display("[TB] FAIL arb_reuse got %b/%0d want 1/1", bus.arvalid_o, bus.arid_o);
    end
    @(negedge clk);
  endtask

  task automatic test_reorder();
    logic [80:0] dN;
    int slot;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      send_req(1'b0, mk(1'b0, 16'h3000 + 16'(i), 8'h10 + 8'(i), 56'(i)), slot);
      checks++;
      if (bus.arid_o !== IDW'(i)) begin
        errors++;
        $display("[TB] FAIL ord_arid got %0d want %0d", bus.arid_o, i);
      end
      @(negedge clk);
    end
    dN = mk(1'b1, 16'h3333, 8'h77, 56'h77);
    bus.rd_req_valid_i = 1'b1;
    bus.rd_req_data_i  = dN;
    bus.rvalid_i = 1'b1;
    bus.rid_i    = 2'd2;
    bus.rtag_i   = 8'hFF;
    #1;
    checks++;
    if (bus.rd_req_ready_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ord_nofree got %b want 0", bus.rd_req_ready_o);
    end
    model_resp(2, 8'hFF);
    @(negedge clk);
    bus.rid_i  = 2'd0;
    bus.rtag_i = 8'h10;
    #1;
    checks++;
    if (bus.rd_req_ready_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ord_freed got %b want 1", bus.rd_req_ready_o);
    end
    slot = model_alloc(1'b0, dN);
    model_resp(0, 8'h10);
    @(negedge clk);
    bus.rd_req_valid_i = 1'b0;
    bus.rid_i  = 2'd3;
    bus.rtag_i = 8'h13;
    checks++;
    if ({bus.arvalid_o, bus.arid_o} !== {1'b1, 2'd2}) begin
      errors++;
      $display("[TB] FAIL ord_alloc got %b/%0d want 1/2", bus.arvalid_o, bus.arid_o);
    end
    model_resp(3, 8'h13);
    @(negedge clk);
    bus.rid_i  = 2'd1;
    bus.rtag_i = 8'h00;
    model_resp(1, 8'h00);
    @(negedge clk);
    bus.rvalid_i = 1'b0;
    @(negedge clk);
    send_resp(2, 8'h77);
    bus.rvalid_i = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.outstanding_o !== 3'd0) begin
      errors++;
      $display("[TB] FAIL ord_drain got %0d want 0", bus.outstanding_o);
    end
  endtask

  task automatic test_backpressure();
    logic [80:0] d0;
    int slot;
    do_reset();
    d0 = mk(1'b1, 16'h4444, 8'h40, 56'h40);
    send_req(1'b0, d0, slot);
    @(negedge clk);
    send_req(1'b0, mk(1'b0, 16'h4445, 8'h41, 56'h41), slot);
    @(negedge clk);
    send_req(1'b0, mk(1'b0, 16'h4446, 8'h42, 56'h42), slot);
    @(negedge clk);
    bus.out_ready_i = 1'b0;
    send_resp(0, 8'h40);
    bus.rid_i  = 2'd1;
    bus.rtag_i = 8'h41;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if ({bus.rready_o, bus.out_valid_o, bus.out_data_o} !== {1'b0, 1'b1, 1'b0, d0[79:0]}) begin
        errors++;
        $display("[TB] FAIL bp_hold cycle %0d got rready=%b v=%b data=%h want 0/1/%h",
                 c, bus.rready_o, bus.out_valid_o, bus.out_data_o, {1'b0, d0[79:0]});
      end
      @(negedge clk);
    end
    bus.out_ready_i = 1'b1;
    model_resp(1, 8'h41);
    @(negedge clk);
    bus.rid_i  = 2'd2;
    bus.rtag_i = 8'h99;
    model_resp(2, 8'h99);
    checks++;
    if (bus.out_valid_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_stream1 got %b want 1", bus.out_valid_o);
    end
    @(negedge clk);
    bus.rvalid_i = 1'b0;
    checks++;
    if (bus.out_valid_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_stream2 got %b want 1", bus.out_valid_o);
    end
    @(negedge clk);
    checks++;
    if ({bus.out_valid_o, bus.outstanding_o} !== {1'b0, 3'd0}) begin
      errors++;
      $display("[TB] FAIL bp_drain got v=%b outst=%0d want 0/0", bus.out_valid_o, bus.outstanding_o);
    end
  endtask

  task automatic test_orphan_reset();
    int slot;
    do_reset();
    send_resp(1, 8'h00);
    bus.rvalid_i = 1'b0;
    checks++;
    if ({bus.orphan_err_o, bus.out_valid_o} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL orphan_set got orphan=%b v=%b want 1/0", bus.orphan_err_o, bus.out_valid_o);
    end
    bus.arready_i = 1'b0;
    send_req(1'b0, mk(1'b0, 16'h5555, 8'h50, 56'h50), slot);
    checks++;
    if (bus.arvalid_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rst_pre got arvalid=%b want 1", bus.arvalid_o);
    end
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.arvalid_o, bus.araddr_o, bus.outstanding_o, bus.orphan_err_o, bus.out_valid_o, bus.rready_o}
        !== {1'b0, 64'd0, 3'd0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("[TB] FAIL rst_async got ar=%b addr=%h outst=%0d orphan=%b v=%b rready=%b want 0/0/0/0/0/1",
               bus.arvalid_o, bus.araddr_o, bus.outstanding_o, bus.orphan_err_o, bus.out_valid_o, bus.rready_o);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    bus.arready_i = 1'b1;
    send_resp(0, 8'h50);
    bus.rvalid_i = 1'b0;
    checks++;
    if ({bus.orphan_err_o, bus.out_valid_o} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL rst_orphan got orphan=%b v=%b want 1/0", bus.orphan_err_o, bus.out_valid_o);
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus_idle();
    test_reset();
    test_single_read();
    test_write();
    test_arbitration();
    test_reorder();
    test_backpressure();
    test_orphan_reset();
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL sb_leftover got %0d pending want 0", expQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/tag_probe_sched.md
# tag_probe_sched

Tag-probe scheduler for the DRAM cache front end. It arbitrates between a read-request stream and a write-request stream and issues one tag-probe read per request on an AXI-style AR channel. It tracks up to MAX_OUTSTANDING probes in flight, matches each returning R beat (rid, rtag, rdata) to its request, and compares tags. Each classified request (read/write × hit/miss) is handed to the reordering buffer through a single valid/ready output.

## Interface
Parameters:
- TAG_BIT_SIZE, 8: tag width. Request tag = req[63 : 64-TAG_BIT_SIZE].
- MAX_OUTSTANDING, 4: probe slots, power of two, 2..16.
- ID_W, 2: arid/rid width, equal to log2(MAX_OUTSTANDING).

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- rd_req_valid_i / rd_req_ready_o  in/out  1  read request handshake.
- rd_req_data_i  in  81  request word: [80] ignored, [79:64] meta, [63:0] address.
- wr_req_valid_i / wr_req_ready_o  in/out  1  write request handshake.
- wr_req_data_i  in  81  same layout as rd_req_data_i.
- arvalid_o / arready_i  out/in  1  probe issue handshake.
- araddr_o  out  64  probe address, equal to request [63:0].
- arid_o  out  ID_W  slot index.
- rvalid_i / rready_o  in/out  1  probe response handshake.
- rid_i  in  ID_W  slot of the response.
- rtag_i  in  TAG_BIT_SIZE  tag stored in DRAM cache.
- rdata_i  in  64  carried, unused for compare.
- out_valid_o / out_ready_i  out/in  1  classified-request handshake.
- out_data_o  out  81  stored request; [80]=1 if write.
- out_class_o  out  2  0 RHIT, 1 RMISS, 2 WHIT, 3 WMISS.
- outstanding_o  out  ID_W+1  occupied slot count.
- orphan_err_o  out  1  sticky: response arrived for a free slot.

## Operation
- Slot table: MAX_OUTSTANDING entries, each holding a valid bit and an 81-bit request. The request's [80] is overwritten with 0 for read and 1 for write.
- Issue FSM:
  - S_IDLE: if any slot is free, grant one requester. Only the granted *_req_ready_o is 1.
  - On the grant handshake: latch the request into the lowest-index free slot (per the pre-edge free vector), then go to S_ISSUE.
  - S_ISSUE: arvalid_o=1 with araddr_o/arid_o held stable until arready_i. Then go to S_IDLE.
  - In S_ISSUE, both *_req_ready_o are 0.
- Arbitration: when only one requester is valid, grant it. When both are valid, grant the one not granted last. The last-grant pointer resets to "write", so read wins the first tie.
- No free slot: both *_req_ready_o are 0. arvalid_o is never asserted without a valid slot.
- Response path:
  - rready_o = !out_valid_o || out_ready_i.
  - On an rvalid_i&&rready_o handshake with slot[rid_i] valid:
    - Compare rtag_i with the slot tag.
    - Load out_data_o and out_class_o. Class = {write bit, mismatch}.
    - Set out_valid_o and free the slot.
  - If slot[rid_i] is invalid: the beat is consumed, orphan_err_o is set (sticky until rst), and there is no output.
- Responses may return in any rid order. Outputs appear in response order, with no reordering.
- outstanding_o counts valid slots, covering both allocated-not-issued and issued.

## Timing
- Reset values:
  - All slots invalid; FSM in S_IDLE; last-grant pointer = write.
  - arvalid_o, araddr_o, arid_o = 0.
  - out_valid_o, out_data_o, out_class_o = 0.
  - outstanding_o = 0, orphan_err_o = 0.
  - rready_o = 1 and *_req_ready_o follow the rules above (combinational).
- Request accepted at edge t: arvalid_o is 1 from t+1.
- R handshake at edge t: out_valid_o is 1 from t+1. Output holds stable until out_ready_i.
- Full throughput: one response per cycle when out_ready_i stays 1. Issue rate is at most one probe per two cycles.
- Simultaneous slot free (response) and allocation (grant) in one cycle: the allocation cannot use the freed slot. The freed slot is usable from the next cycle.
- A response with rid_i equal to a slot still in S_ISSUE is legal and treated normally.
- rst asserted mid-operation clears everything immediately. Responses arriving after reset for pre-reset probes set orphan_err_o.

## Configuration
- TAG_PROBE_SCHED_STATS_EN defined: adds four 32-bit saturating output ports, rhit_cnt_o, rmiss_cnt_o, whit_cnt_o, wmiss_cnt_o.
  - Each increments on its class at the out_valid_o&&out_ready_i handshake.
  - Reset value is 0; each holds at 0xFFFFFFFF.
- Not defined: these ports and counters are absent. Behaviour is otherwise identical.

## Test plan
- Single read, address 0xAB00_0000_0000_1234, response rid=0, rtag=0xAB → out_class=0, out_data[80]=0, orphan_err=0. arvalid at t+1 and out_valid at t+1 after each respective handshake.
- Write, address tag 0x12, rtag=0x13 → out_class=3, out_data[80]=1; outstanding_o returns 1→0.
- Both valid continuously with responses delayed → grants alternate R,W,R,W. Grants stop when outstanding_o=4, with both ready low until a response frees a slot.
- Four probes issued (arid 0..3), responses in order 2,0,3,1 → four outputs in the same order; the slot freed each cycle is reallocated only one cycle later.
- out_ready_i low for 5 cycles with responses pending → rready_o low, out_data stable. Then one output per cycle once ready rises.
- Response rid=1 with no slot 1 allocated → orphan_err_o=1, no out_valid. rst pulse mid-stream → all outputs return to reset values asynchronously.
